// File: rtl/mem_req_arbiter_pkg.sv
// Shared constants and types for the instruction/data memory request arbiter.
package mem_req_arbiter_pkg;

    localparam int CPU_INST_BITS          = 32;
    localparam int CPU_ADDR_BITS          = 32;
    localparam int DEFAULT_WORD_ADDR_BITS = CPU_ADDR_BITS - $clog2(CPU_INST_BITS / 8);
    localparam int STARVE_CNT_BITS        = 4;
    localparam int WRITE_EN_BITS          = 4;

    // Which port owns an outstanding read; stored one bit per FIFO entry.
    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_e;

    function automatic logic is_read(input logic [WRITE_EN_BITS-1:0] write_en);
        return write_en == '0;
    endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Bundle of the fetch, data and memory-side channels seen by the arbiter.
interface mem_req_arbiter_if
    import mem_req_arbiter_pkg::*;
#(
    parameter int CPU_WIDTH      = CPU_INST_BITS,
    parameter int WORD_ADDR_BITS = DEFAULT_WORD_ADDR_BITS
);

    logic                      imem_req_valid;
    logic                      imem_req_ready;
    logic [WORD_ADDR_BITS-1:0] imem_req_addr;
    logic                      imem_resp_valid;
    logic [CPU_WIDTH-1:0]      imem_resp_data;

    logic                      dmem_req_valid;
    logic                      dmem_req_ready;
    logic [WORD_ADDR_BITS-1:0] dmem_req_addr;
    logic [CPU_WIDTH-1:0]      dmem_req_data;
    logic [WRITE_EN_BITS-1:0]  dmem_req_write;
    logic                      dmem_resp_valid;
    logic [CPU_WIDTH-1:0]      dmem_resp_data;

    logic                      mem_req_valid;
    logic                      mem_req_ready;
    logic [WORD_ADDR_BITS-1:0] mem_req_addr;
    logic [CPU_WIDTH-1:0]      mem_req_data;
    logic [WRITE_EN_BITS-1:0]  mem_req_write;
    logic                      mem_resp_valid;
    logic [CPU_WIDTH-1:0]      mem_resp_data;

    // Arbiter view.
    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        input  dmem_req_valid, dmem_req_addr, dmem_req_data, dmem_req_write,
        output dmem_req_ready, dmem_resp_valid, dmem_resp_data,
        output mem_req_valid, mem_req_addr, mem_req_data, mem_req_write,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );

    // Environment view: CPU ports plus memory.
    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        output dmem_req_valid, dmem_req_addr, dmem_req_data, dmem_req_write,
        input  dmem_req_ready, dmem_resp_valid, dmem_resp_data,
        input  mem_req_valid, mem_req_addr, mem_req_data, mem_req_write,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );

endinterface

// File: rtl/mem_req_arbiter_resp_owner_fifo.sv
// Small FIFO recording the owner of each outstanding read, head visible combinationally.
module resp_owner_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    always_comb begin
        empty   = (count_reg == '0);
        full    = (count_reg == CNT_W'(DEPTH));
        do_pop  = pop && !empty;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        do_push = push && (!full || do_pop);
        head    = mem_reg[rd_ptr_reg];
        count   = count_reg;
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= next_ptr(wr_ptr_reg);
            if (do_pop)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Merges fetch and data ports onto one memory channel, data first with bounded fetch starvation,
// and routes in-order read responses back to the requesting port.
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int CPU_WIDTH       = CPU_INST_BITS,
    parameter int WORD_ADDR_BITS  = DEFAULT_WORD_ADDR_BITS,
    parameter int STARVE_LIMIT    = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic               clk,
    input  logic               reset,
    mem_req_arbiter_if.slave   bus,
    output logic               err_spurious
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [STARVE_CNT_BITS-1:0] STARVE_MAX = STARVE_CNT_BITS'(STARVE_LIMIT);

    logic [CNT_W-1:0]           owner_count;
    logic                       owner_full, owner_empty, owner_push, owner_pop;
    logic [0:0]                 owner_in, owner_head;
    logic                       can_read, d_is_read;
    logic                       elig_i, elig_d, grant_i, grant_d, fire_i, fire_d;
    logic [WORD_ADDR_BITS-1:0]  req_addr;
    logic [CPU_WIDTH-1:0]       req_data, resp_data;
    logic [STARVE_CNT_BITS-1:0] starve_cnt_reg, starve_cnt_next;
    logic                       err_spurious_reg;

    resp_owner_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (1)
    ) u_owner_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (owner_push),
        .push_data (owner_in),
        .pop       (owner_pop),
        .head      (owner_head),
        .count     (owner_count),
        .full      (owner_full),
        .empty     (owner_empty)
    );

    always_comb begin
        d_is_read = is_read(bus.dmem_req_write);
        // A response retiring this cycle frees a slot for a same-cycle read.
        can_read  = (owner_count < CNT_W'(MAX_OUTSTANDING)) || (bus.mem_resp_valid && !owner_empty);
        elig_i    = !reset && bus.imem_req_valid && can_read;
        elig_d    = !reset && bus.dmem_req_valid && (!d_is_read || can_read);
        grant_i   = elig_i && (!elig_d || starve_cnt_reg == STARVE_MAX);
        grant_d   = elig_d && !grant_i;
        fire_i    = grant_i && bus.mem_req_ready;
        fire_d    = grant_d && bus.mem_req_ready;

        owner_pop  = bus.mem_resp_valid && !owner_empty;
        owner_push = (fire_i || (fire_d && d_is_read)) && (!owner_full || owner_pop);
        owner_in   = fire_i ? 1'(OWNER_I) : 1'(OWNER_D);

        req_addr  = grant_d ? bus.dmem_req_addr : (grant_i ? bus.imem_req_addr : '0);
        req_data  = grant_d ? bus.dmem_req_data : '0;
        resp_data = reset ? '0 : bus.mem_resp_data;

        bus.mem_req_valid   = grant_i || grant_d;
        bus.mem_req_addr    = req_addr;
        bus.mem_req_data    = req_data;
        bus.mem_req_write   = grant_d ? bus.dmem_req_write : '0;
        bus.imem_req_ready  = fire_i;
        bus.dmem_req_ready  = fire_d;
        bus.imem_resp_valid = !reset && owner_pop && (owner_head == 1'(OWNER_I));
        bus.dmem_resp_valid = !reset && owner_pop && (owner_head == 1'(OWNER_D));
        bus.imem_resp_data  = resp_data;
        bus.dmem_resp_data  = resp_data;

        // Counts data wins against a waiting fetch; any fetch win or idle fetch resets it.
        starve_cnt_next = starve_cnt_reg;
        if (!bus.imem_req_valid || fire_i) begin
            starve_cnt_next = '0;
        end else if (fire_d && starve_cnt_reg != STARVE_MAX) begin
            starve_cnt_next = starve_cnt_reg + STARVE_CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_reg   <= '0;
            err_spurious_reg <= 1'b0;
        end else begin
            starve_cnt_reg   <= starve_cnt_next;
            err_spurious_reg <= err_spurious_reg || (bus.mem_resp_valid && owner_empty);
        end
    end

    assign err_spurious = err_spurious_reg;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter with a 1-cycle-latency memory model that can be stalled.
module tb_mem_req_arbiter;
    import mem_req_arbiter_pkg::*;

    localparam int AW    = DEFAULT_WORD_ADDR_BITS;
    localparam int DW    = 32;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic reset;
    logic err_spurious;

    always #5 clk = ~clk;

    mem_req_arbiter_if #(.CPU_WIDTH(DW), .WORD_ADDR_BITS(AW)) bus();

    mem_req_arbiter #(
        .CPU_WIDTH       (DW),
        .WORD_ADDR_BITS  (AW),
        .STARVE_LIMIT    (LIMIT),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .err_spurious (err_spurious)
    );

    typedef struct packed {
        logic          is_d;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] mem_q[$];
    bit            resp_en;
    int            checks;
    int            errors;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return 32'hDEADBEEF ^ 32'(a) ^ 32'h10;
    endfunction

    task automatic expect_resp(input logic is_d, input logic [AW-1:0] a);
        exp_t e;
        e.is_d = is_d;
        e.data = mem_word(a);
        exp_q.push_back(e);
    endtask

    task automatic idle_inputs();
        bus.imem_req_valid = 1'b0;
        bus.imem_req_addr  = '0;
        bus.dmem_req_valid = 1'b0;
        bus.dmem_req_addr  = '0;
        bus.dmem_req_data  = '0;
        bus.dmem_req_write = '0;
    endtask

    task automatic settle();
        #2;
    endtask

    // Scoreboard compare, memory model bookkeeping, then advance to the next negedge.
    task automatic tick();
        logic [1:0]    obs;
        logic [1:0]    req;
        logic [DW-1:0] obs_data;
        exp_t          e;
        obs = {bus.dmem_resp_valid, bus.imem_resp_valid};
        if (obs != 2'b00) begin
            checks++;
            obs_data = bus.dmem_resp_valid ? bus.dmem_resp_data : bus.imem_resp_data;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected: got {d,i} valid=%b data=%h, required no response", obs, obs_data);
            end else begin
                e   = exp_q.pop_front();
                req = e.is_d ? 2'b10 : 2'b01;
                if (obs !== req || obs_data !== e.data) begin
                    errors++;
                    $display("FAIL resp_route: got {d,i}=%b data=%h, required {d,i}=%b data=%h",
                             obs, obs_data, req, e.data);
                end else begin
                    $display("resp %s data=%h", e.is_d ? "D" : "I", obs_data);
                end
            end
        end else if (bus.mem_resp_valid && exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL resp_missing: got no resp valid, required %s data=%h",
                     exp_q[0].is_d ? "D" : "I", exp_q[0].data);
        end
        if (bus.mem_req_valid && bus.mem_req_ready) begin
            $display("req addr=%h write=%h data=%h", bus.mem_req_addr, bus.mem_req_write, bus.mem_req_data);
            if (bus.mem_req_write == '0) mem_q.push_back(mem_word(bus.mem_req_addr));
        end
        if (bus.mem_resp_valid && mem_q.size() != 0) mem_q.delete(0);
        @(negedge clk);
        bus.mem_resp_valid = resp_en && (mem_q.size() != 0);
        bus.mem_resp_data  = bus.mem_resp_valid ? mem_q[0] : '0;
    endtask

    task automatic test_reset();
        bus.imem_req_valid = 1'b1;
        bus.imem_req_addr  = AW'(5);
        bus.dmem_req_valid = 1'b1;
        bus.dmem_req_addr  = AW'(6);
        bus.dmem_req_data  = 32'h1111_2222;
        bus.mem_req_ready  = 1'b1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'hFFFF_FFFF;
        settle();
        checks++;
        if ({bus.mem_req_valid, bus.imem_req_ready, bus.dmem_req_ready,
             bus.imem_resp_valid, bus.dmem_resp_valid, err_spurious} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, required 000000", {bus.mem_req_valid, bus.imem_req_ready,
                     bus.dmem_req_ready, bus.imem_resp_valid, bus.dmem_resp_valid, err_spurious});
        end
        checks++;
        if (bus.mem_req_addr !== '0 || bus.mem_req_data !== '0 || bus.mem_req_write !== '0 ||
            bus.imem_resp_data !== '0 || bus.dmem_resp_data !== '0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h data=%h write=%h irsp=%h drsp=%h, required all 0",
                     bus.mem_req_addr, bus.mem_req_data, bus.mem_req_write, bus.imem_resp_data, bus.dmem_resp_data);
        end
        checks++;
        if (dut.owner_count !== '0 || dut.starve_cnt_reg !== '0) begin
            errors++;
            $display("FAIL reset_state: got count=%0d starve=%0d, required 0 and 0", dut.owner_count, dut.starve_cnt_reg);
        end
        idle_inputs();
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        reset = 1'b0;
        settle();
        checks++;
        if (bus.mem_req_valid !== 1'b0 || err_spurious !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got valid=%b err=%b, required 0 and 0", bus.mem_req_valid, err_spurious);
        end
        tick();
    endtask

    task automatic test_lone_fetch();
        bus.imem_req_valid = 1'b1;
        bus.imem_req_addr  = AW'(16);
        settle();
        checks++;
        if ({bus.mem_req_valid, bus.imem_req_ready, bus.dmem_req_ready} !== 3'b110 ||
            bus.mem_req_addr !== AW'(16) || bus.mem_req_write !== '0 || bus.mem_req_data !== '0) begin
            errors++;
            $display("FAIL lone_req: got v/ir/dr=%b addr=%h write=%h data=%h, required 110 addr=10 write=0 data=0",
                     {bus.mem_req_valid, bus.imem_req_ready, bus.dmem_req_ready},
                     bus.mem_req_addr, bus.mem_req_write, bus.mem_req_data);
        end
        expect_resp(1'b0, AW'(16));
        tick();
        idle_inputs();
        settle();
        checks++;
        if (bus.imem_resp_valid !== 1'b1 || bus.imem_resp_data !== 32'hDEADBEEF || bus.dmem_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL lone_resp: got iv=%b data=%h dv=%b, required iv=1 data=deadbeef dv=0",
                     bus.imem_resp_valid, bus.imem_resp_data, bus.dmem_resp_valid);
        end
        tick();
    endtask

    task automatic test_priority();
        bus.imem_req_valid = 1'b1;
        bus.imem_req_addr  = AW'('h20);
        bus.dmem_req_valid = 1'b1;
        bus.dmem_req_addr  = AW'('h30);
        bus.dmem_req_write = 4'b0000;
        settle();
        checks++;
        if ({bus.imem_req_ready, bus.dmem_req_ready} !== 2'b01 || bus.mem_req_addr !== AW'('h30)) begin
            errors++;
            $display("FAIL prio_c0: got ir/dr=%b addr=%h, required 01 addr=30",
                     {bus.imem_req_ready, bus.dmem_req_ready}, bus.mem_req_addr);
        end
        expect_resp(1'b1, AW'('h30));
        tick();
        bus.dmem_req_valid = 1'b0;
        settle();
        checks++;
        if ({bus.imem_req_ready, bus.dmem_req_ready} !== 2'b10 || bus.mem_req_addr !== AW'('h20)) begin
            errors++;
            $display("FAIL prio_c1: got ir/dr=%b addr=%h, required 10 addr=20",
                     {bus.imem_req_ready, bus.dmem_req_ready}, bus.mem_req_addr);
        end
        expect_resp(1'b0, AW'('h20));
        tick();
        idle_inputs();
        settle();
        tick();
    endtask

    task automatic test_starvation();
        int   model_cnt;
        logic exp_i;
        model_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            bus.imem_req_valid = 1'b1;
            bus.imem_req_addr  = AW'('h40);
            bus.dmem_req_valid = 1'b1;
            bus.dmem_req_addr  = AW'(256 + c);
            bus.dmem_req_data  = 32'(c);
            bus.dmem_req_write = 4'hF;
            settle();
            exp_i = (model_cnt == LIMIT);
            checks++;
            if ({bus.imem_req_ready, bus.dmem_req_ready} !== {exp_i, !exp_i}) begin
                errors++;
                $display("FAIL starve_grant: cycle %0d got ir/dr=%b, required %b",
                         c, {bus.imem_req_ready, bus.dmem_req_ready}, {exp_i, !exp_i});
            end
            if (exp_i) begin
                expect_resp(1'b0, AW'('h40));
                model_cnt = 0;
            end else begin
                model_cnt = model_cnt + 1;
            end
            tick();
        end
        idle_inputs();
        settle();
        checks++;
        if (dut.starve_cnt_reg !== '0) begin
            errors++;
            $display("FAIL starve_clear: got starve_cnt=%0d, required 0", dut.starve_cnt_reg);
        end
        tick();
    endtask

    task automatic test_full_fifo();
        resp_en = 1'b0;
        bus.imem_req_valid = 1'b1;
        bus.imem_req_addr  = AW'('h50);
        settle();
        checks++;
        if (bus.imem_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_fill0: got ir=%b, required 1", bus.imem_req_ready);
        end
        expect_resp(1'b0, AW'('h50));
        tick();
        bus.imem_req_valid = 1'b0;
        bus.dmem_req_valid = 1'b1;
        bus.dmem_req_addr  = AW'('h60);
        bus.dmem_req_write = 4'b0000;
        settle();
        checks++;
        if (bus.dmem_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_fill1: got dr=%b, required 1", bus.dmem_req_ready);
        end
        expect_resp(1'b1, AW'('h60));
        tick();
        bus.imem_req_valid = 1'b1;
        bus.imem_req_addr  = AW'('h70);
        bus.dmem_req_addr  = AW'('h80);
        bus.dmem_req_data  = 32'h0000_CAFE;
        bus.dmem_req_write = 4'b0011;
        settle();
        checks++;
        if (dut.owner_count !== 2'd2) begin
            errors++;
            $display("FAIL full_count: got count=%0d, required 2", dut.owner_count);
        end
        checks++;
        if ({bus.imem_req_ready, bus.dmem_req_ready} !== 2'b01 || bus.mem_req_write !== 4'b0011) begin
            errors++;
            $display("FAIL full_write: got ir/dr=%b write=%b, required 01 write=0011",
                     {bus.imem_req_ready, bus.dmem_req_ready}, bus.mem_req_write);
        end
        tick();
        bus.dmem_req_valid = 1'b0;
        bus.dmem_req_write = 4'b0000;
        settle();
        checks++;
        if (bus.imem_req_ready !== 1'b0 || bus.mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_block: got ir=%b mem_valid=%b, required 0 and 0", bus.imem_req_ready, bus.mem_req_valid);
        end
        resp_en = 1'b1;
        tick();
        settle();
        checks++;
        if (bus.imem_req_ready !== 1'b1 || bus.mem_resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_pushpop: got ir=%b resp_valid=%b, required 1 and 1", bus.imem_req_ready, bus.mem_resp_valid);
        end
        expect_resp(1'b0, AW'('h70));
        tick();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            settle();
            tick();
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL full_drain: got %0d responses pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_spurious();
        idle_inputs();
        settle();
        checks++;
        if (err_spurious !== 1'b0) begin
            errors++;
            $display("FAIL spur_pre: got err=%b, required 0", err_spurious);
        end
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'h0000_1234;
        settle();
        checks++;
        if ({bus.imem_resp_valid, bus.dmem_resp_valid} !== 2'b00) begin
            errors++;
            $display("FAIL spur_drop: got iv/dv=%b, required 00", {bus.imem_resp_valid, bus.dmem_resp_valid});
        end
        tick();
        settle();
        checks++;
        if (err_spurious !== 1'b1) begin
            errors++;
            $display("FAIL spur_set: got err=%b, required 1", err_spurious);
        end
        tick();
        tick();
        settle();
        checks++;
        if (err_spurious !== 1'b1) begin
            errors++;
            $display("FAIL spur_hold: got err=%b, required 1", err_spurious);
        end
    endtask

    task automatic test_reset_outstanding();
        reset = 1'b1;
        settle();
        checks++;
        if (err_spurious !== 1'b0) begin
            errors++;
            $display("FAIL rst_err_clear: got err=%b, required 0", err_spurious);
        end
        reset = 1'b0;
        resp_en = 1'b0;
        tick();
        bus.imem_req_valid = 1'b1;
        bus.imem_req_addr  = AW'('h90);
        settle();
        tick();
        idle_inputs();
        settle();
        checks++;
        if (dut.owner_count !== 2'd1) begin
            errors++;
            $display("FAIL rst_pre: got count=%0d, required 1", dut.owner_count);
        end
        reset = 1'b1;
        settle();
        checks++;
        if (dut.owner_count !== '0 || {bus.mem_req_valid, bus.imem_req_ready, bus.dmem_req_ready,
            bus.imem_resp_valid, bus.dmem_resp_valid, err_spurious} !== 6'b0) begin
            errors++;
            $display("FAIL rst_clear: got count=%0d ctrl=%b, required 0 and 000000", dut.owner_count,
                     {bus.mem_req_valid, bus.imem_req_ready, bus.dmem_req_ready,
                      bus.imem_resp_valid, bus.dmem_resp_valid, err_spurious});
        end
        reset = 1'b0;
        resp_en = 1'b1;
        tick();
        settle();
        checks++;
        if (bus.mem_resp_valid !== 1'b1 || {bus.imem_resp_valid, bus.dmem_resp_valid} !== 2'b00) begin
            errors++;
            $display("FAIL rst_late_drop: got resp_valid=%b iv/dv=%b, required 1 and 00",
                     bus.mem_resp_valid, {bus.imem_resp_valid, bus.dmem_resp_valid});
        end
        tick();
        settle();
        checks++;
        if (err_spurious !== 1'b1) begin
            errors++;
            $display("FAIL rst_late_err: got err=%b, required 1", err_spurious);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        resp_en = 1'b1;
        reset   = 1'b1;
        idle_inputs();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        @(negedge clk);
        test_reset();
        test_lone_fetch();
        test_priority();
        test_starvation();
        test_full_fifo();
        test_spurious();
        test_reset_outstanding();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
